// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 responder model.
package ltc2308_pkg;

   localparam int DATA_BITS = 12;
   localparam int CHANNELS  = 8;
   localparam int CFG_BITS  = 6;

   // Config word layout, MSB first: S/D, O/S, S1, S0, UNI, SLP
   localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 6'b100010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   // {S1,S0,O/S} read as a binary number is the channel index (O/S picks odd channels).
   function automatic logic [2:0] cfg_to_channel(input logic [2:0] sel);
      return sel;
   endfunction

endpackage

// File: rtl/ltc2308_emulator_pin_sync.sv
// Multi-stage synchronizer for one SPI pin, with single-cycle rise/fall strobes.
module spi_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ltc2308_emulator.sv
// LTC2308 SPI ADC responder: answers CONVST/SCK/SDI and shifts out per-channel
// values taken from a parallel bus, oversampling the SPI pins on clk.
module ltc2308_emulator
   import ltc2308_pkg::*;
#(
   parameter int CONV_CYCLES = 130,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           adc_convst,
   input  logic                           adc_sck,
   input  logic                           adc_sdi,
   output logic                           adc_sdo,
   input  logic [CHANNELS*DATA_BITS-1:0]  ch_data,
   output logic                           busy,
   output logic                           frame_done,
   output logic [CFG_BITS-1:0]            last_cfg,
   output logic                           cfg_error
);

   localparam int CW = $clog2(CONV_CYCLES + 1);

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] res_q, res_d;
   logic                 sdo_q, sdo_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [2:0]           rx_cnt_q, rx_cnt_d;
   logic [CFG_BITS-1:0]  cfg_shift_q, cfg_shift_d;
   logic [CFG_BITS-1:0]  last_cfg_q, last_cfg_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 fdone_q, fdone_d;

   logic convst_lvl, convst_rise, convst_fall;
   logic sck_lvl, sck_rise, sck_fall;
   logic sdi_lvl, sdi_rise, sdi_fall;
   logic sync_unused;

   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_convst (
      .clk(clk), .reset_n(reset_n), .pin_i(adc_convst),
      .level_o(convst_lvl), .rise_o(convst_rise), .fall_o(convst_fall)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .reset_n(reset_n), .pin_i(adc_sck),
      .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk(clk), .reset_n(reset_n), .pin_i(adc_sdi),
      .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
   );

   assign sync_unused = &{convst_lvl, convst_fall, sck_lvl, sdi_rise, sdi_fall};

   // A fully received config is committed on abort, so the restarted conversion uses it.
   logic [CFG_BITS-1:0]  conv_cfg;
   logic [2:0]           conv_ch;
   logic [DATA_BITS-1:0] conv_raw;
   logic [DATA_BITS-1:0] conv_result;

   always_comb begin
      conv_cfg = (state_q == SHIFT && rx_cnt_q == 3'd6) ? cfg_shift_q : last_cfg_q;
      conv_ch  = cfg_to_channel({conv_cfg[3], conv_cfg[2], conv_cfg[4]});
      conv_raw = ch_data[int'(conv_ch)*DATA_BITS +: DATA_BITS];
      if (!conv_cfg[5])
         conv_result = '0;
      else if (!conv_cfg[1])
         conv_result = conv_raw ^ 12'h800;
      else
         conv_result = conv_raw;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         res_q       <= '0;
         sdo_q       <= 1'b0;
         bit_cnt_q   <= '0;
         rx_cnt_q    <= '0;
         cfg_shift_q <= '0;
         last_cfg_q  <= CFG_DEFAULT;
         cfg_err_q   <= 1'b0;
         fdone_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         sdo_q       <= sdo_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         cfg_shift_q <= cfg_shift_d;
         last_cfg_q  <= last_cfg_d;
         cfg_err_q   <= cfg_err_d;
         fdone_q     <= fdone_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      sdo_d       = sdo_q;
      bit_cnt_d   = bit_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      cfg_shift_d = cfg_shift_q;
      last_cfg_d  = last_cfg_q;
      cfg_err_d   = cfg_err_q;
      fdone_d     = 1'b0;

      case (state_q)
         IDLE: begin
            sdo_d = 1'b0;
            if (convst_rise) begin
               res_d   = conv_result;
               cnt_d   = CW'(CONV_CYCLES - 1);
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            sdo_d = 1'b0;
            if (cnt_q == '0) begin
               state_d   = SHIFT;
               sdo_d     = res_q[DATA_BITS-1];
               bit_cnt_d = '0;
               rx_cnt_d  = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SHIFT: begin
            if (convst_rise) begin
               if (rx_cnt_q == 3'd6)
                  last_cfg_d = cfg_shift_q;
               res_d   = conv_result;
               cnt_d   = CW'(CONV_CYCLES - 1);
               sdo_d   = 1'b0;
               state_d = CONVERT;
            end else if (sck_rise) begin
               if (rx_cnt_q < 3'd6) begin
                  cfg_shift_d = {cfg_shift_q[CFG_BITS-2:0], sdi_lvl};
                  rx_cnt_d    = rx_cnt_q + 1'b1;
               end
               bit_cnt_d = bit_cnt_q + 1'b1;
               // Twelfth rise: the full config word is already in cfg_shift_q.
               if (bit_cnt_q == 4'd11) begin
                  fdone_d    = 1'b1;
                  last_cfg_d = cfg_shift_q;
                  cfg_err_d  = cfg_err_q | ~cfg_shift_q[5];
                  sdo_d      = 1'b0;
                  state_d    = IDLE;
               end
            end else if (sck_fall) begin
               sdo_d = res_q[DATA_BITS-2];
               res_d = {res_q[DATA_BITS-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign adc_sdo    = sdo_q;
   assign busy       = (state_q == CONVERT);
   assign frame_done = fdone_q;
   assign last_cfg   = last_cfg_q;
   assign cfg_error  = cfg_err_q;

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Directed self-checking bench for ltc2308_emulator.
module tb_ltc2308_emulator;

   localparam int CONV   = 130;
   localparam int SYNC   = 2;
   localparam int FALL_K = CONV + SYNC + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        adc_convst = 1'b0;
   logic        adc_sck = 1'b0;
   logic        adc_sdi = 1'b0;
   logic        adc_sdo;
   logic [95:0] ch_data = '0;
   logic        busy;
   logic        frame_done;
   logic [5:0]  last_cfg;
   logic        cfg_error;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cyc  = 0;

   ltc2308_emulator #(.CONV_CYCLES(CONV), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset_n(reset_n), .adc_convst(adc_convst), .adc_sck(adc_sck),
      .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .ch_data(ch_data), .busy(busy),
      .frame_done(frame_done), .last_cfg(last_cfg), .cfg_error(cfg_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_done) fd_cyc <= fd_cyc + 1;

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int n, input logic [11:0] v);
      ch_data[n*12 +: 12] = v;
   endtask

   // Pulse CONVST and measure the busy window; fall_k = -1 on timeout.
   task automatic start_conv(input bit mid_pulse, output int fall_k, output int width,
                             output int sdo_bad);
      bit seen = 0;
      fall_k = -1; width = 0; sdo_bad = 0;
      adc_convst = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         if (k == 4) adc_convst = 1'b0;
         if (mid_pulse && k == 50) adc_convst = 1'b1;
         if (mid_pulse && k == 54) adc_convst = 1'b0;
         if (busy) begin
            seen = 1; width++;
            if (adc_sdo) sdo_bad++;
         end else if (seen) begin
            fall_k = k;
            break;
         end
      end
      adc_convst = 1'b0;
   endtask

   // Clock nbits SCK periods (10 clk each), sending cfg MSB first and capturing SDO before each rise.
   task automatic spi_frame(input logic [5:0] cfg, input int nbits, output logic [11:0] rd);
      rd = '0;
      for (int i = 0; i < nbits; i++) begin
         adc_sdi = (i < 6) ? cfg[5-i] : 1'b0;
         clks(5);
         rd[11-i] = adc_sdo;
         adc_sck = 1'b1;
         clks(5);
         adc_sck = 1'b0;
      end
      adc_sdi = 1'b0;
      clks(6);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      clks(3);
      reset_n = 1'b1;
      clks(2);
      n_tests++; if (adc_sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got %b exp 0", adc_sdo); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_tests++; if (last_cfg !== 6'b100010) begin n_fail++; $display("FAIL reset_cfg got %b exp 100010", last_cfg); end
      n_tests++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", cfg_error); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", frame_done); end
   endtask

   task automatic test_idle_sck;
      logic [11:0] rd;
      int fd0 = fd_cyc;
      spi_frame(6'b000000, 12, rd);
      n_tests++; if (fd_cyc !== fd0) begin n_fail++; $display("FAIL idle_fd got %0d exp %0d", fd_cyc, fd0); end
      n_tests++; if (rd !== 12'h000) begin n_fail++; $display("FAIL idle_sdo got %h exp 000", rd); end
      n_tests++; if (last_cfg !== 6'b100010) begin n_fail++; $display("FAIL idle_cfg got %b exp 100010", last_cfg); end
   endtask

   task automatic test_basic_frame;
      int fk, w, sb, fd0;
      logic [11:0] rd;
      set_ch(0, 12'hABC);
      start_conv(0, fk, w, sb);
      n_tests++; if (fk != FALL_K) begin n_fail++; $display("FAIL basic_busy_fall got %0d exp %0d", fk, FALL_K); end
      n_tests++; if (w != CONV) begin n_fail++; $display("FAIL basic_busy_width got %0d exp %0d", w, CONV); end
      n_tests++; if (sb != 0) begin n_fail++; $display("FAIL basic_sdo_in_convert got %0d exp 0", sb); end
      fd0 = fd_cyc;
      spi_frame(6'b110010, 12, rd);
      n_tests++; if (rd !== 12'hABC) begin n_fail++; $display("FAIL basic_sdo got %h exp abc", rd); end
      n_tests++; if (fd_cyc != fd0 + 1) begin n_fail++; $display("FAIL basic_fd_pulse got %0d exp %0d", fd_cyc - fd0, 1); end
      n_tests++; if (last_cfg !== 6'b110010) begin n_fail++; $display("FAIL basic_cfg got %b exp 110010", last_cfg); end
      n_tests++; if (adc_sdo !== 1'b0) begin n_fail++; $display("FAIL basic_sdo_idle got %b exp 0", adc_sdo); end
   endtask

   task automatic test_pipelined_channel;
      int fk, w, sb;
      logic [11:0] rd;
      set_ch(1, 12'h123);
      start_conv(0, fk, w, sb);
      n_tests++; if (fk != FALL_K) begin n_fail++; $display("FAIL pipe_busy_fall got %0d exp %0d", fk, FALL_K); end
      spi_frame(6'b100000, 12, rd);
      n_tests++; if (rd !== 12'h123) begin n_fail++; $display("FAIL pipe_sdo got %h exp 123", rd); end
      n_tests++; if (last_cfg !== 6'b100000) begin n_fail++; $display("FAIL pipe_cfg got %b exp 100000", last_cfg); end
   endtask

   task automatic test_bipolar;
      int fk, w, sb;
      logic [11:0] rd;
      set_ch(0, 12'h000);
      start_conv(0, fk, w, sb);
      set_ch(0, 12'hFFF);
      spi_frame(6'b100010, 12, rd);
      n_tests++; if (rd !== 12'h800) begin n_fail++; $display("FAIL bipolar_sdo got %h exp 800", rd); end
      n_tests++; if (last_cfg !== 6'b100010) begin n_fail++; $display("FAIL bipolar_cfg got %b exp 100010", last_cfg); end
   endtask

   task automatic test_abort;
      int fk, w, sb, fd0;
      logic [11:0] rd;
      set_ch(0, 12'h5A5);
      start_conv(1, fk, w, sb);
      n_tests++; if (fk != FALL_K) begin n_fail++; $display("FAIL abort_ignored_fall got %0d exp %0d", fk, FALL_K); end
      n_tests++; if (w != CONV) begin n_fail++; $display("FAIL abort_ignored_width got %0d exp %0d", w, CONV); end
      fd0 = fd_cyc;
      spi_frame(6'b010110, 3, rd);
      start_conv(0, fk, w, sb);
      n_tests++; if (w != CONV) begin n_fail++; $display("FAIL abort_busy_width got %0d exp %0d", w, CONV); end
      n_tests++; if (fd_cyc != fd0) begin n_fail++; $display("FAIL abort_fd got %0d exp %0d", fd_cyc - fd0, 0); end
      n_tests++; if (last_cfg !== 6'b100010) begin n_fail++; $display("FAIL abort_cfg got %b exp 100010", last_cfg); end
      spi_frame(6'b000010, 12, rd);
      n_tests++; if (rd !== 12'h5A5) begin n_fail++; $display("FAIL abort_sdo got %h exp 5a5", rd); end
      n_tests++; if (fd_cyc != fd0 + 1) begin n_fail++; $display("FAIL abort_fd_after got %0d exp %0d", fd_cyc - fd0, 1); end
   endtask

   task automatic test_cfg_error;
      int fk, w, sb;
      logic [11:0] rd;
      n_tests++; if (cfg_error !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", cfg_error); end
      n_tests++; if (last_cfg !== 6'b000010) begin n_fail++; $display("FAIL err_cfg got %b exp 000010", last_cfg); end
      start_conv(0, fk, w, sb);
      spi_frame(6'b100010, 12, rd);
      n_tests++; if (rd !== 12'h000) begin n_fail++; $display("FAIL err_sdo got %h exp 000", rd); end
      n_tests++; if (cfg_error !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", cfg_error); end
      n_tests++; if (last_cfg !== 6'b100010) begin n_fail++; $display("FAIL err_cfg2 got %b exp 100010", last_cfg); end
      reset_n = 1'b0;
      clks(2);
      reset_n = 1'b1;
      clks(1);
      n_tests++; if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL err_reset got %b exp 0", cfg_error); end
      n_tests++; if (last_cfg !== 6'b100010) begin n_fail++; $display("FAIL err_reset_cfg got %b exp 100010", last_cfg); end
   endtask

   initial begin
      test_reset;
      test_idle_sck;
      test_basic_frame;
      test_pipelined_channel;
      test_bipolar;
      test_abort;
      test_cfg_error;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
